stage_if_fq: RTL and testbench
==============================

// Module: stage_if_fq
// PURPOSE
//  Next-generation fetch stage: PC sequencer plus external 1-cycle-latency
//  instruction-memory port, and a parametrised fetch queue decoupling fetch
//  from decode via valid/ready handshake. Expands custom W-type instructions
//  into tagged base RV32I ops (35-bit output) at queue write; branch
//  redirect flushes the queue and kills in-flight fetches.
// PARAMETERS
//  FQ_DEPTH   4            fetch-queue entries (power of 2, >=2)
//  RESET_PC   32'h0        PC loaded on reset
//  WTYPE_OPC  7'b0001011   opcode of W-type macro instructions
//  F3_INS1    3'b000       funct3: load  -> lw rd,imm(rs1), tag 3'b100
//  F3_INS2    3'b001       funct3: store -> sw, tag 3'b010
//  F3_INS3    3'b010       funct3: mv rd,rs1 -> addi rd,rs1,0, tag 3'b100
//  F3_INS4    3'b011       funct3: mv rd,rs2 -> addi rd,inst[24:20],0, tag 3'b001
// PORTS
//  clk         in   1   clock
//  rst         in   1   synchronous reset, active-low
//  br_ctrl     in   1   redirect request (taken branch/jump)
//  br_addr     in   32  redirect target
//  imem_req    out  1   fetch request this cycle
//  imem_addr   out  32  fetch address (word-aligned)
//  imem_rdata  in   32  instruction, valid cycle after imem_req
//  if_valid    out  1   queue head valid
//  if_ready    in   1   decode accepts head
//  if_inst     out  35  {tag[2:0], inst[31:0]} of head
//  if_pc       out  32  PC of head
// BEHAVIOUR
//  Reset (rst=0 at clk edge): pc=RESET_PC, queue empty, inflight=0,
//   kill=0; outputs imem_req=0, if_valid=0, if_inst=0, if_pc=0 while rst=0.
//  Issue: imem_req=1 iff rst=1, !br_ctrl, and count+inflight < FQ_DEPTH;
//   imem_addr=pc; on issue pc<=pc+4, inflight<=1 (max 1 outstanding/cycle,
//   back-to-back issue allowed: issue and return in same cycle).
//  Return: cycle after issue, if !kill and !br_ctrl, write {expand(rdata),
//   issued pc} at tail. Fetch-to-if_valid latency = 2 cycles.
//  Expansion (at write, combinational on rdata): opcode==WTYPE_OPC and
//   funct3 matches: INS1 {100,i[31:15],010,i[11:7],0000011};
//   INS2 {010,i[31:15],010,i[11:7],0100011};
//   INS3 {100,12'b0,i[19:15],000,i[11:7],0010011};
//   INS4 {001,12'b0,i[24:20],000,i[11:7],0010011};
//   all else {000,i}. W-type with other funct3 passes through, tag 000.
//  Pop: if_valid && if_ready && !br_ctrl -> head advances.
//  Full: no issue, no drop; push and pop same cycle when full allowed only
//   via returning fetch (count unchanged).
//  Empty: if_valid=0; if_inst/if_pc hold last value (don't-care).
//  Redirect: br_ctrl=1 -> pc<=br_addr, queue emptied, any in-flight return
//   next cycle discarded (kill=1 for that cycle), no issue this cycle;
//   pop in same cycle is void. First target issue cycle after br_ctrl.
//  Back-to-back br_ctrl: last one wins; kill covers each.
//  Pointers wrap modulo FQ_DEPTH; count width clog2(FQ_DEPTH)+1.
//  Reset mid-operation: all state cleared next edge, in-flight data dropped.
// TESTING
//  Reset, rst=0 3 cycles then 1, if_ready=1 -> imem_addr 0,4,8...; first
//   if_valid 2 cycles after first imem_req, if_pc=0.
//  if_ready=0 streaming -> exactly 4 entries, imem_req drops to 0,
//   no entry lost; if_ready=1 -> PCs 0,4,8,12,16 in order.
//  rdata=32'h0101028B (W INS1, rd=x5, rs1=x2, imm=16) -> if_inst=35'h4_0101_2283;
//   INS2/INS3/INS4 and non-W (32'h00000013 -> tag 000) checked likewise.
//  br_ctrl=1, br_addr=32'h100 with fetch in flight and 3 queued -> queue
//   empty next cycle, stale return dropped, next if_pc=32'h100.
//  br_ctrl with simultaneous if_ready and full queue -> no pop counted,
//   queue empty, imem_req=0 that cycle.
//  rst=0 asserted with 2 queued and one in flight -> if_valid=0 next
//   cycle, restart at RESET_PC, no stale instruction emitted.

Source files
------------

// File: rtl/stage_if_fq.sv
// Fetch stage: PC sequencer driving a 1-cycle instruction memory, W-type macro
// expansion at queue write, and a small fetch queue handed to decode via valid/ready.
module stage_if_fq #(
  parameter int unsigned FQ_DEPTH  = 4,
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter logic [6:0]  WTYPE_OPC = 7'b0001011,
  parameter logic [2:0]  F3_INS1   = 3'b000,
  parameter logic [2:0]  F3_INS2   = 3'b001,
  parameter logic [2:0]  F3_INS3   = 3'b010,
  parameter logic [2:0]  F3_INS4   = 3'b011
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        br_ctrl,
  input  logic [31:0] br_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [34:0] if_inst,
  output logic [31:0] if_pc
);
  localparam int unsigned PW = $clog2(FQ_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FQ_DEPTH);
  localparam logic [CW:0]   DEPTH_X = (CW+1)'(FQ_DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          inflight_q, inflight_d;
  logic          kill_q, kill_d;
  logic [31:0]   ipc_q, ipc_d;
  logic [34:0]   inst_mem_q [FQ_DEPTH];
  logic [34:0]   inst_mem_d [FQ_DEPTH];
  logic [31:0]   pc_mem_q   [FQ_DEPTH];
  logic [31:0]   pc_mem_d   [FQ_DEPTH];

  logic [CW:0]   occ;
  logic          issue, push, pop;
  logic [34:0]   expanded;

  always_comb begin
    expanded = {3'b000, imem_rdata};
    if (imem_rdata[6:0] == WTYPE_OPC) begin
      if (imem_rdata[14:12] == F3_INS1)
        expanded = {3'b100, imem_rdata[31:15], 3'b010, imem_rdata[11:7], 7'b0000011};
      else if (imem_rdata[14:12] == F3_INS2)
        expanded = {3'b010, imem_rdata[31:15], 3'b010, imem_rdata[11:7], 7'b0100011};
      else if (imem_rdata[14:12] == F3_INS3)
        expanded = {3'b100, 12'b0, imem_rdata[19:15], 3'b000, imem_rdata[11:7], 7'b0010011};
      else if (imem_rdata[14:12] == F3_INS4)
        expanded = {3'b001, 12'b0, imem_rdata[24:20], 3'b000, imem_rdata[11:7], 7'b0010011};
    end
  end

  always_comb begin
    occ   = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    issue = rst && !br_ctrl && (occ < DEPTH_X);
    pop   = (count_q != '0) && if_ready && !br_ctrl;
    // A returning fetch may land in a full queue only when the head leaves the same cycle.
    push  = inflight_q && !kill_q && !br_ctrl && ((count_q < DEPTH_C) || pop);

    pc_d       = pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    inflight_d = issue;
    kill_d     = 1'b0;
    ipc_d      = ipc_q;
    inst_mem_d = inst_mem_q;
    pc_mem_d   = pc_mem_q;

    if (br_ctrl) begin
      pc_d    = {br_addr[31:2], 2'b00};
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      kill_d  = 1'b1;
    end else begin
      if (issue) begin
        pc_d  = pc_q + 32'd4;
        ipc_d = pc_q;
      end
      if (push) begin
        inst_mem_d[tail_q] = expanded;
        pc_mem_d[tail_q]   = ipc_q;
        tail_d             = tail_q + PW'(1);
      end
      if (pop) head_d = head_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
      ipc_q      <= '0;
      inst_mem_q <= '{default: '0};
      pc_mem_q   <= '{default: '0};
    end else begin
      pc_q       <= pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
      ipc_q      <= ipc_d;
      inst_mem_q <= inst_mem_d;
      pc_mem_q   <= pc_mem_d;
    end
  end

  always_comb begin
    imem_req  = issue;
    imem_addr = {pc_q[31:2], 2'b00};
    if_valid  = rst && (count_q != '0);
    if_inst   = rst ? inst_mem_q[head_q] : '0;
    if_pc     = rst ? pc_mem_q[head_q] : '0;
  end
endmodule

// File: tb/tb_stage_if_fq.sv
// Bench for stage_if_fq: directed phases plus an instruction-memory model; every
// issued fetch pushes its expected {inst, pc} and a monitor checks each accepted head.
module tb_stage_if_fq;
  logic        clk;
  logic        rst;
  logic        br_ctrl;
  logic [31:0] br_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [34:0] if_inst;
  logic [31:0] if_pc;

  int unsigned n_pass;
  int unsigned n_total;
  logic [66:0] sb[$];
  logic [31:0] next_rdata;

  stage_if_fq #(.FQ_DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .br_ctrl(br_ctrl), .br_addr(br_addr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst), .if_pc(if_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] prog(input logic [31:0] a);
    case (a)
      32'h200: return 32'h0101028B;
      32'h204: return 32'h0020920B;
      32'h208: return 32'hABC3A30B;
      32'h20C: return 32'h0090350B;
      32'h210: return 32'h0000708B;
      32'h214: return 32'h00000013;
      default: return {a[11:0], 20'h00013};
    endcase
  endfunction

  function automatic logic [34:0] exp_of(input logic [31:0] a);
    case (a)
      32'h200: return 35'h4_0101_2283;
      32'h204: return 35'h2_0020_A223;
      32'h208: return 35'h4_0003_8313;
      32'h20C: return 35'h1_0004_8513;
      32'h210: return 35'h0_0000_708B;
      32'h214: return 35'h0_0000_0013;
      default: return {3'b000, a[11:0], 20'h00013};
    endcase
  endfunction

  task automatic chk(input string name, input logic [66:0] act, input logic [66:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h expected=%h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  // Memory returns the word the cycle after a request; junk otherwise.
  initial begin
    imem_rdata = 32'hDEADBEEF;
    forever begin
      @(posedge clk);
      #1;
      imem_rdata = next_rdata;
    end
  end

  always @(negedge clk) begin
    logic [66:0] e;
    next_rdata = 32'hDEADBEEF;
    if (!rst || br_ctrl) begin
      chk("no_issue_flush", {66'b0, imem_req}, 67'd0);
      sb.delete();
    end else begin
      if (if_valid && if_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_pop", {if_inst, if_pc}, 67'd0);
        end else begin
          e = sb.pop_front();
          chk("pop_inst_pc", {if_inst, if_pc}, e);
        end
      end
      if (imem_req) begin
        sb.push_back({exp_of(imem_addr), imem_addr});
        next_rdata = prog(imem_addr);
      end
    end
  end

  initial begin
    n_pass = 0;
    n_total = 0;
    next_rdata = 32'hDEADBEEF;
    rst = 1'b0;
    br_ctrl = 1'b0;
    br_addr = 32'h0;
    if_ready = 1'b1;

    for (int i = 0; i < 3; i++) begin
      step();
      at_neg();
      chk("rst_req", {66'b0, imem_req}, 67'd0);
      chk("rst_valid", {66'b0, if_valid}, 67'd0);
      chk("rst_inst_pc", {if_inst, if_pc}, 67'd0);
    end

    // Fill with decode stalled.
    step(); rst = 1'b1; if_ready = 1'b0;
    at_neg();
    chk("first_req", {66'b0, imem_req}, 67'd1);
    chk("addr0", {35'b0, imem_addr}, 67'h0);
    chk("valid_lat0", {66'b0, if_valid}, 67'd0);
    step(); at_neg();
    chk("addr4", {35'b0, imem_addr}, 67'h4);
    chk("valid_lat1", {66'b0, if_valid}, 67'd0);
    step(); at_neg();
    chk("addr8", {35'b0, imem_addr}, 67'h8);
    chk("valid_lat2", {66'b0, if_valid}, 67'd1);
    chk("first_pc", {35'b0, if_pc}, 67'h0);
    repeat (6) step();
    at_neg();
    chk("full_no_req", {66'b0, imem_req}, 67'd0);
    chk("full_entries", 67'(sb.size()), 67'd4);
    chk("full_valid", {66'b0, if_valid}, 67'd1);
    step(); if_ready = 1'b1;
    repeat (10) step();

    // Expansion of W-type words.
    step(); br_ctrl = 1'b1; br_addr = 32'h200;
    at_neg();
    chk("br_no_req", {66'b0, imem_req}, 67'd0);
    step(); br_ctrl = 1'b0;
    repeat (12) step();

    // Redirect with three queued and one fetch in flight.
    step(); if_ready = 1'b0; br_ctrl = 1'b1; br_addr = 32'h40;
    step(); br_ctrl = 1'b0;
    step(); step(); step();
    at_neg();
    chk("pre_br_entries", 67'(sb.size()), 67'd4);
    step(); br_ctrl = 1'b1; br_addr = 32'h100;
    at_neg();
    chk("br_req_low", {66'b0, imem_req}, 67'd0);
    chk("br_valid_still", {66'b0, if_valid}, 67'd1);
    step(); br_ctrl = 1'b0;
    at_neg();
    chk("post_br_empty", {66'b0, if_valid}, 67'd0);
    chk("post_br_addr", {34'b0, imem_req, imem_addr}, {34'b0, 1'b1, 32'h100});
    step(); if_ready = 1'b1;
    repeat (8) step();

    // Redirect while full and decode ready: the pop is void.
    step(); if_ready = 1'b0;
    repeat (8) step();
    step(); if_ready = 1'b1; br_ctrl = 1'b1; br_addr = 32'h40;
    at_neg();
    chk("full_br_req", {66'b0, imem_req}, 67'd0);
    step(); br_ctrl = 1'b0; if_ready = 1'b0;
    at_neg();
    chk("full_br_empty", {66'b0, if_valid}, 67'd0);
    step(); if_ready = 1'b1;
    repeat (6) step();

    // Back-to-back redirects: the later target wins.
    step(); br_ctrl = 1'b1; br_addr = 32'h80;
    step(); br_addr = 32'h180;
    step(); br_ctrl = 1'b0;
    at_neg();
    chk("b2b_addr", {35'b0, imem_addr}, 67'h180);
    repeat (6) step();

    // Reset with two queued and one in flight.
    step(); if_ready = 1'b0; br_ctrl = 1'b1; br_addr = 32'h300;
    step(); br_ctrl = 1'b0;
    step(); step(); step();
    rst = 1'b0;
    at_neg();
    chk("midrst_req", {66'b0, imem_req}, 67'd0);
    chk("midrst_valid", {66'b0, if_valid}, 67'd0);
    chk("midrst_inst_pc", {if_inst, if_pc}, 67'd0);
    step(); rst = 1'b1; if_ready = 1'b1;
    at_neg();
    chk("restart_valid", {66'b0, if_valid}, 67'd0);
    chk("restart_addr", {34'b0, imem_req, imem_addr}, {34'b0, 1'b1, 32'h0});
    repeat (8) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
